// File: rtl/uart_phy.sv
// uart_phy -- byte-level UART serialiser/deserialiser for the command front end.
//
// One shared 16x oversampling tick drives both directions. Frames are
// 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), 16 ticks per bit.
//
// Ports
//   clk           system clock (single domain)
//   rst_n         asynchronous active-low reset
//   divisor       clk cycles per 16x tick; 0 behaves like 1
//   uart_rx       serial input, asynchronous to clk
//   uart_tx       serial output, idles high
//   rx_data       last correctly framed byte
//   rx_done       1-cycle strobe, rx_data just updated
//   rx_frame_err  1-cycle strobe, stop bit was sampled low
//   tx_data       byte to send, captured when tx_wr is accepted
//   tx_wr         1-cycle send request, accepted only while tx_busy=0
//   tx_busy       transmitter occupied
//   tx_done       1-cycle strobe at the end of the stop bit
module uart_phy #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic [7:0]       rx_data,
  output logic             rx_done,
  output logic             rx_frame_err,
  input  logic [7:0]       tx_data,
  input  logic             tx_wr,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  rx_state_t        rx_state;
  logic [3:0]       rx_tick_cnt;
  logic [2:0]       rx_bit_cnt;
  logic [7:0]       rx_shift;

  tx_state_t        tx_state;
  logic [3:0]       tx_tick_cnt;
  logic [2:0]       tx_bit_cnt;
  logic [7:0]       tx_shift;

  // Tick fires while the down-counter sits at zero. The reload value is read
  // only at that moment, so a new divisor is picked up at the next reload.
  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (divisor == '0) ? '0 : (divisor - DIV_ONE);
    end else begin
      tick_cnt <= tick_cnt - DIV_ONE;
    end
  end

  // Receiver. uart_rx is only used through the two-flop synchroniser; rx_prev
  // holds the previous synced value for start-edge detection. The start bit is
  // re-checked at its middle (8 ticks) to reject glitches, after which every
  // 16th tick lands in the middle of the following bits. After a bad stop bit
  // the line is treated as a break and no new frame starts until it goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_tick_cnt  <= '0;
      rx_bit_cnt   <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= uart_rx;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state    <= RX_START;
            rx_tick_cnt <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick_cnt == 4'd7) begin
              rx_tick_cnt <= '0;
              rx_bit_cnt  <= '0;
              rx_state    <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_shift   <= {rx_s2, rx_shift[7:1]};
              rx_bit_cnt <= rx_bit_cnt + 3'd1;
              if (rx_bit_cnt == 3'd7) begin
                rx_state <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              if (rx_s2) begin
                rx_data  <= rx_shift;
                rx_done  <= 1'b1;
                rx_state <= RX_IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                rx_state     <= RX_BREAK;
              end
            end
          end
        end
        RX_BREAK: begin
          if (rx_s2) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter. uart_tx drops the clock after a write is accepted; each bit
  // ends on its 16th tick. tx_done and tx_busy=0 appear together, and since
  // the FSM is then idle a tx_wr in that same cycle starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      uart_tx     <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_shift    <= tx_data;
            tx_busy     <= 1'b1;
            uart_tx     <= 1'b0;
            tx_tick_cnt <= '0;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              uart_tx    <= tx_shift[0];
              tx_bit_cnt <= '0;
              tx_state   <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              if (tx_bit_cnt == 3'd7) begin
                uart_tx  <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                uart_tx    <= tx_shift[1];
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
              end
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy -- self-checking bench for uart_phy.
// RX frames come from a table of directed vectors; the TX bit pattern,
// loopback stream and mid-frame reset are hand-written sequences.
`timescale 1ns/1ps
module tb_uart_phy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] divisor = 16'd1;
  logic        rx_drive = 1'b1;
  logic        loopback = 1'b0;
  logic        rx_line;
  logic        uart_tx;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_frame_err;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr = 1'b0;
  logic        tx_busy;
  logic        tx_done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int txdone_cnt = 0;

  typedef struct {
    bit          glitch;
    logic [15:0] div;
    logic [7:0]  data;
    logic        stop;
    int          exp_done;
    int          exp_err;
    logic [7:0]  exp_data;
  } rx_vec_t;

  rx_vec_t vecs[5];

  assign rx_line = loopback ? uart_tx : rx_drive;

  uart_phy #(.DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .divisor      (divisor),
    .uart_rx      (rx_line),
    .uart_tx      (uart_tx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled at posedge so they see pre-update values.
  always @(posedge clk) begin
    if (rx_done === 1'b1) done_cnt++;
    if (rx_frame_err === 1'b1) err_cnt++;
    if (tx_done === 1'b1) txdone_cnt++;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stop, input int bit_clks);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drive = bits[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (!stop) begin
      repeat (200) @(negedge clk);
      rx_drive = 1'b1;
    end
    repeat (3 * bit_clks) @(negedge clk);
  endtask

  task automatic applyStimulus(input rx_vec_t v);
    @(negedge clk);
    divisor = v.div;
    repeat (4) @(negedge clk);
    if (v.glitch) begin
      rx_drive = 1'b0;
      repeat (4) @(negedge clk);
      rx_drive = 1'b1;
      repeat (60) @(negedge clk);
    end else begin
      sendFrame(v.data, v.stop, 16 * int'(v.div));
    end
  endtask

  function automatic logic [7:0] lbByte(input int i);
    if (i == 63) return 8'hFF;
    return 8'((i * 37) & 255);
  endfunction

  initial begin
    int d0, e0, t0, bad, busy_bad;
    bit got;
    logic [9:0] bits;

    vecs[0] = '{1'b0, 16'd1, 8'h12, 1'b1, 1, 0, 8'h12};
    vecs[1] = '{1'b1, 16'd1, 8'h00, 1'b1, 0, 0, 8'h12};
    vecs[2] = '{1'b0, 16'd1, 8'h34, 1'b1, 1, 0, 8'h34};
    vecs[3] = '{1'b0, 16'd2, 8'hA5, 1'b0, 0, 1, 8'h34};
    vecs[4] = '{1'b0, 16'd2, 8'h56, 1'b1, 1, 0, 8'h56};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset rx_done", 32'(rx_done), 32'd0);
    checkOutput("reset rx_frame_err", 32'(rx_frame_err), 32'd0);
    checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven RX vectors
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d rx_done count", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d rx_frame_err count", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
    end

    // TX bit pattern for 0x56 at divisor 1, with an ignored write mid-frame
    @(negedge clk);
    divisor = 16'd1;
    repeat (4) @(negedge clk);
    t0 = txdone_cnt;
    tx_data = 8'h56;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    bits = 10'b1_0101_0110_0;
    busy_bad = 0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (uart_tx !== bits[b]) bad++;
        if (tx_busy !== 1'b1) busy_bad++;
        if (b == 5 && c == 0) begin
          tx_data = 8'hFF;
          tx_wr = 1'b1;
        end else if (b == 5 && c == 1) begin
          tx_wr = 1'b0;
        end
      end
      checkOutput($sformatf("tx bit %0d clocks wrong", b), 32'(bad), 32'd0);
    end
    checkOutput("tx_busy low during frame", 32'(busy_bad), 32'd0);
    checkOutput("tx_done early", 32'(txdone_cnt - t0), 32'd0);
    @(negedge clk);
    checkOutput("tx_done after stop", 32'(tx_done), 32'd1);
    checkOutput("tx_busy after stop", 32'(tx_busy), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("ignored write not queued busy", 32'(tx_busy), 32'd0);
    checkOutput("ignored write not queued line", 32'(uart_tx), 32'd1);
    checkOutput("tx_done pulses", 32'(txdone_cnt - t0), 32'd1);

    // Loopback at divisor 3, back-to-back frames
    divisor = 16'd3;
    loopback = 1'b1;
    e0 = err_cnt;
    repeat (10) @(negedge clk);
    tx_data = lbByte(0);
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
        @(negedge clk);
        if (rx_done === 1'b1) got = 1'b1;
      end
      checkOutput($sformatf("loopback byte %0d", i), got ? 32'(rx_data) : 32'hDEAD, 32'(lbByte(i)));
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
        if (tx_done === 1'b1) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) checkOutput($sformatf("loopback tx_done timeout %0d", i), 32'd0, 32'd1);
      if (i < 63) begin
        tx_data = lbByte(i + 1);
        tx_wr = 1'b1;
      end
      @(negedge clk);
      tx_wr = 1'b0;
    end
    repeat (20) @(negedge clk);
    checkOutput("loopback frame errors", 32'(err_cnt - e0), 32'd0);
    loopback = 1'b0;

    // Reset in the middle of an RX and a TX frame
    divisor = 16'd1;
    repeat (10) @(negedge clk);
    tx_data = 8'hA5;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    rx_drive = 1'b0;
    repeat (16) @(negedge clk);
    rx_drive = 1'b0;
    repeat (16) @(negedge clk);
    rx_drive = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("mid reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("mid reset rx_done", 32'(rx_done), 32'd0);
    checkOutput("mid reset rx_frame_err", 32'(rx_frame_err), 32'd0);
    checkOutput("mid reset tx_done", 32'(tx_done), 32'd0);
    checkOutput("mid reset rx_data", 32'(rx_data), 32'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    t0 = txdone_cnt;
    repeat (300) @(negedge clk);
    checkOutput("post reset rx_done none", 32'(done_cnt - d0), 32'd0);
    checkOutput("post reset tx_done none", 32'(txdone_cnt - t0), 32'd0);
    checkOutput("post reset uart_tx idle", 32'(uart_tx), 32'd1);
    sendFrame(8'h12, 1'b1, 16);
    checkOutput("post reset rx_done count", 32'(done_cnt - d0), 32'd1);
    checkOutput("post reset rx_data", 32'(rx_data), 32'h12);
    checkOutput("post reset frame errors", 32'(err_cnt - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
